// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU.
// Default register-file geometry, plus the register index and data word
// types sized from it. Blocks built with other geometries size their
// ports from their own parameters.
package cpu_types_pkg;

  localparam int NREGS_DEF  = 32;
  localparam int DWIDTH_DEF = 32;
  localparam int RSEL_W     = $clog2(NREGS_DEF);

  typedef logic [RSEL_W-1:0]     regsel_t;
  typedef logic [DWIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/write_decoder.sv
// One-hot register enable decoder.
//   en_i      global enable (writeback WEN or issue claim)
//   sel_i     target register index
//   onehot_o  per-register enable; bit 0 is never set because register 0
//             is hard-wired to zero and can be neither written nor claimed
module write_decoder #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic          en_i,
  input  logic [SW-1:0] sel_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 1; i < N; i++) onehot_o[i] = en_i && (sel_i == SW'(i));
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with busy scoreboard.
// NREGS x DWIDTH storage, one writeback port, two combinational read ports,
// register 0 reads as zero. A busy bit per register is set when an
// instruction claims it as a destination and cleared on writeback, so
// hazard logic can stall on in-flight results.
//   CLK, nRST            clock, async active-low reset
//   WEN, wsel, wdat      writeback port
//   rsel1/2 -> rdat1/2   read ports (optional same-cycle bypass)
//   claim, csel          issue-time destination claim
//   busy1/2              busy bit of rsel1/rsel2 (bypass-aware)
//   nbusy                registered count of busy registers
module regfile_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int BYPASS = 1,
  parameter int SW     = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              WEN,
  input  logic [SW-1:0]     wsel,
  input  logic [DWIDTH-1:0] wdat,
  input  logic [SW-1:0]     rsel1,
  input  logic [SW-1:0]     rsel2,
  output logic [DWIDTH-1:0] rdat1,
  output logic [DWIDTH-1:0] rdat2,
  input  logic              claim,
  input  logic [SW-1:0]     csel,
  output logic              busy1,
  output logic              busy2,
  output logic [SW:0]       nbusy
);

  logic [NREGS-1:0][DWIDTH-1:0] regs_q;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic [SW:0]                  nbusy_q;
  logic [NREGS-1:0]             wen_oh, clm_oh;

  function automatic logic [SW:0] popcount(input logic [NREGS-1:0] v);
    logic [SW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (SW+1)'(v[i]);
    return c;
  endfunction

  write_decoder #(.N(NREGS), .SW(SW)) u_wdec (
    .en_i     (WEN),
    .sel_i    (wsel),
    .onehot_o (wen_oh)
  );

  write_decoder #(.N(NREGS), .SW(SW)) u_cdec (
    .en_i     (claim),
    .sel_i    (csel),
    .onehot_o (clm_oh)
  );

  // Claim is applied after the clear: a same-cycle claim belongs to a newer
  // producer than the instruction writing back, so the register stays busy.
  always_comb busy_d = (busy_q & ~wen_oh) | clm_oh;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs_q  <= '0;
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wen_oh[i]) regs_q[i] <= wdat;
      busy_q  <= busy_d;
      nbusy_q <= popcount(busy_d);
    end
  end

  // wen_oh[rsel] already folds in WEN, the index match and the reg-0
  // exclusion, so it doubles as the bypass hit. Outputs are forced low while
  // reset is held so a pending writeback cannot leak through the bypass.
  always_comb begin
    rdat1 = regs_q[rsel1];
    rdat2 = regs_q[rsel2];
    busy1 = busy_q[rsel1];
    busy2 = busy_q[rsel2];
    if (BYPASS != 0) begin
      if (wen_oh[rsel1]) rdat1 = wdat;
      if (wen_oh[rsel2]) rdat2 = wdat;
      if (wen_oh[rsel1] && !clm_oh[rsel1]) busy1 = 1'b0;
      if (wen_oh[rsel2] && !clm_oh[rsel2]) busy2 = 1'b0;
    end
    if (!nRST) begin
      rdat1 = '0;
      rdat2 = '0;
      busy1 = 1'b0;
      busy2 = 1'b0;
    end
  end

  assign nbusy = nbusy_q;

endmodule
